// File: rtl/v_tile_vec.sv
// Vector tile: network-writable register file feeding a multi-width SIMD
// add/sub unit; one operation per start pulse, result on a valid/ready port.
module v_tile_vec #(
  parameter int unsigned LANE_W    = 16,
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned NUM_REGS  = 16,
  localparam int unsigned DATA_W   = LANE_W * NUM_LANES,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_en,
  input  logic [AW-1:0]        w_addr,
  input  logic [DATA_W-1:0]    w_data_in,
  output logic                 write_rdy,
  output logic                 write_ack,
  input  logic                 start,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_dir,
  output logic [DATA_W-1:0]    out_data,
  output logic [NUM_LANES-1:0] out_ovf,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_SEND
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic                 wr_fire;
  logic                 handshake;

  // Operation context captured in READ
  logic [1:0]           mode_q;
  logic                 sub_q;
  logic                 sat_q;
  logic [1:0]           dir_q;
  logic [DATA_W-1:0]    a_q;
  logic [DATA_W-1:0]    b_q;

  // Per-mode results, selected by the latched mode
  logic [DATA_W-1:0]    res_m [4];
  logic [NUM_LANES-1:0] ovf_m [4];

  assign wr_fire   = write_en && write_rdy;
  assign handshake = out_valid && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: linear sequence, SEND waits for the consumer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_SEND;
      S_SEND:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    write_rdy = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE:  write_rdy = 1'b1;
      S_READ:  busy = 1'b1;
      S_EXEC:  busy = 1'b1;
      S_SEND:  begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: write_rdy = 1'b0;
    endcase
  end

  // Register file; writes only land while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_fire) begin
      regs_q[w_addr] <= w_data_in;
    end
  end

  // Write acknowledge, one cycle after the accepting edge
  always_ff @(posedge clk) begin
    if (reset) write_ack <= 1'b0;
    else       write_ack <= wr_fire;
  end

  // Latch config fields and both operands in READ
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= '0;
      sub_q  <= 1'b0;
      sat_q  <= 1'b0;
      dir_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (state_q == S_READ) begin
      mode_q <= regs_q[0][1:0];
      sub_q  <= regs_q[0][2];
      sat_q  <= regs_q[0][3];
      dir_q  <= regs_q[0][5:4];
      a_q    <= regs_q[regs_q[0][6 +: AW]];
      b_q    <= regs_q[regs_q[0][6+AW +: AW]];
    end
  end

  // One adder array per mode; modes wider than the vector collapse to full width
  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam int unsigned EW_RAW = LANE_W << m;
    localparam int unsigned EW     = (EW_RAW > DATA_W) ? DATA_W : EW_RAW;
    localparam int unsigned NE     = DATA_W / EW;
    localparam int unsigned LPE    = EW / LANE_W;

    logic [DATA_W-1:0]    res;
    logic [NUM_LANES-1:0] ovf;

    // Subtract is A + ~B + 1, so a missing carry-out is the borrow
    always_comb begin
      logic [EW:0]   sum;
      logic [EW-1:0] bop;
      logic          flow;
      res  = '0;
      ovf  = '0;
      sum  = '0;
      bop  = '0;
      flow = 1'b0;
      for (int unsigned e = 0; e < NE; e++) begin
        bop  = sub_q ? ~b_q[e*EW +: EW] : b_q[e*EW +: EW];
        sum  = {1'b0, a_q[e*EW +: EW]} + {1'b0, bop} + {{EW{1'b0}}, sub_q};
        flow = sub_q ? ~sum[EW] : sum[EW];
        if (sat_q && flow) res[e*EW +: EW] = sub_q ? '0 : '1;
        else               res[e*EW +: EW] = sum[EW-1:0];
        ovf[(e+1)*LPE-1] = flow;
      end
    end

    assign res_m[m] = res;
    assign ovf_m[m] = ovf;
  end

  // Register the selected result in EXEC; held stable through SEND
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      out_ovf  <= '0;
      out_dir  <= '0;
    end else if (state_q == S_EXEC) begin
      out_data <= res_m[mode_q];
      out_ovf  <= ovf_m[mode_q];
      out_dir  <= dir_q;
    end
  end

  // Completion pulse following the output handshake
  always_ff @(posedge clk) begin
    if (reset) done <= 1'b0;
    else       done <= handshake;
  end

endmodule

// File: tb/tb_v_tile_vec.sv
// Scoreboard bench for v_tile_vec at default parameters.
module tb_v_tile_vec;

  localparam int unsigned LW = 16;
  localparam int unsigned NL = 4;
  localparam int unsigned DW = LW * NL;
  localparam int unsigned NR = 16;
  localparam int unsigned AW = 4;

  typedef struct {
    logic [DW-1:0] d;
    logic [NL-1:0] o;
    logic [1:0]    dir;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          write_en;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data_in;
  logic          write_rdy;
  logic          write_ack;
  logic          start;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_dir;
  logic [DW-1:0] out_data;
  logic [NL-1:0] out_ovf;
  logic          done;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned n_ops = 0;
  int unsigned n_done = 0;
  logic        ack1;

  exp_t          sb[$];
  logic [DW-1:0] shadow [NR];

  v_tile_vec #(.LANE_W(LW), .NUM_LANES(NL), .NUM_REGS(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .write_en  (write_en),
    .w_addr    (w_addr),
    .w_data_in (w_data_in),
    .write_rdy (write_rdy),
    .write_ack (write_ack),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dir   (out_dir),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: element-wise unsigned arithmetic on widened values
  function automatic exp_t model(input logic [DW-1:0] cfg, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b);
    exp_t        r;
    int unsigned ew;
    int unsigned ne;
    logic [DW:0] mask, av, bv, s;
    logic        fl;
    ew = LW << cfg[1:0];
    if (ew > DW) ew = DW;
    ne = DW / ew;
    mask = (65'd1 << ew) - 65'd1;
    r.d = '0;
    r.o = '0;
    r.dir = cfg[5:4];
    for (int unsigned e = 0; e < ne; e++) begin
      av = ({1'b0, a} >> (e*ew)) & mask;
      bv = ({1'b0, b} >> (e*ew)) & mask;
      if (cfg[2]) begin
        fl = av < bv;
        s  = (av - bv) & mask;
        if (fl && cfg[3]) s = '0;
      end else begin
        s  = av + bv;
        fl = s > mask;
        s  = s & mask;
        if (fl && cfg[3]) s = mask;
      end
      r.d = r.d | 64'(s << (e*ew));
      r.o[(e+1)*ew/LW - 1] = fl;
    end
    return r;
  endfunction

  function automatic exp_t from_shadow();
    logic [DW-1:0] c;
    c = shadow[0];
    return model(c, shadow[c[6 +: AW]], shadow[c[6+AW +: AW]]);
  endfunction

  function automatic exp_t lit(input logic [DW-1:0] d, input logic [NL-1:0] o,
                               input logic [1:0] dir);
    exp_t r;
    r.d = d;
    r.o = o;
    r.dir = dir;
    return r;
  endfunction

  // Compare each accepted result against the oldest expectation
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      exp_t e;
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_ovf", 64'(out_ovf), 64'(e.o));
        chk("out_dir", 64'(out_dir), 64'(e.dir));
      end
    end
  end

  always @(negedge clk) if (done) n_done++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write_en = 1'b1;
    w_addr = a;
    w_data_in = d;
    shadow[a] = d;
    tick();
    write_en = 1'b0;
    @(negedge clk);
    chk("write_ack", 64'(write_ack), 64'd1);
  endtask

  // Called at a negedge; start is raised in the current cycle (cycle 0)
  task automatic run_op(input exp_t e);
    int unsigned lat = 0;
    logic        seen = 1'b0;
    sb.push_back(e);
    n_ops++;
    start = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      start = 1'b0;
      write_en = 1'b0;
      lat++;
      @(negedge clk);
      if (lat == 1) ack1 = write_ack;
      if (out_valid) seen = 1'b1;
    end
    chk("latency", 64'(lat), 64'd3);
    if (out_ready) begin
      tick();
      @(negedge clk);
      chk("done_pulse", 64'(done), 64'd1);
      chk("valid_drop", 64'(out_valid), 64'd0);
      chk("idle_rdy", 64'(write_rdy), 64'd1);
    end
  endtask

  initial begin
    exp_t e;
    logic [DW-1:0] r1, r2, cfg;
    reset = 1'b1;
    write_en = 1'b0;
    w_addr = '0;
    w_data_in = '0;
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NR; i++) shadow[i] = '0;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_write_rdy", 64'(write_rdy), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ack", 64'(write_ack), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_ovf_dir", 64'({out_ovf, out_dir}), 64'd0);

    // Held write_en: two accepted writes, two acks
    write_en = 1'b1;
    w_addr = 4'd1;
    w_data_in = 64'h0001_FFFF_0002_0003;
    shadow[1] = w_data_in;
    tick();
    w_addr = 4'd2;
    w_data_in = 64'h0001_0001_0001_0001;
    shadow[2] = w_data_in;
    @(negedge clk);
    chk("burst_ack0", 64'(write_ack), 64'd1);
    tick();
    write_en = 1'b0;
    @(negedge clk);
    chk("burst_ack1", 64'(write_ack), 64'd1);

    // Mode 0 add
    wr(4'd0, 64'h840);
    run_op(lit(64'h0002_0000_0003_0004, 4'b0100, 2'd0));
    // Mode 1 add, started back-to-back is not possible here (write first)
    wr(4'd0, 64'h841);
    run_op(lit(64'h0003_0000_0003_0004, 4'b0000, 2'd0));
    // Immediate restart in the done cycle
    run_op(lit(64'h0003_0000_0003_0004, 4'b0000, 2'd0));

    // Mode 0 saturating subtract toward W
    wr(4'd0, 64'h87C);
    wr(4'd1, 64'h0000_0005_0010_0003);
    wr(4'd2, 64'h0001_0001_0001_0001);
    run_op(lit(64'h0000_0004_000F_0002, 4'b1000, 2'd3));

    // Back-pressure: output held, writes and start ignored
    wr(4'd0, 64'h855);
    e = from_shadow();
    out_ready = 1'b0;
    run_op(e);
    for (int i = 0; i < 5; i++) begin
      tick();
      start = 1'b1;
      write_en = 1'b1;
      w_addr = 4'd1;
      w_data_in = 64'hDEAD_BEEF_0000_FFFF;
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data", out_data, e.d);
      chk("bp_dir", 64'(out_dir), 64'(e.dir));
      chk("bp_no_ack", 64'(write_ack), 64'd0);
      chk("bp_no_done", 64'(done), 64'd0);
    end
    tick();
    start = 1'b0;
    write_en = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_ack_last", 64'(write_ack), 64'd0);
    tick();
    @(negedge clk);
    chk("bp_done", 64'(done), 64'd1);
    tick();
    @(negedge clk);
    chk("bp_single_done", 64'(done), 64'd0);
    chk("bp_start_ignored", 64'(busy), 64'd0);
    // reg1 must still hold its pre-back-pressure value
    wr(4'd0, 64'h840);
    run_op(from_shadow());

    // Reset while in EXEC
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) shadow[i] = '0;
    @(negedge clk);
    chk("rx_busy", 64'(busy), 64'd0);
    chk("rx_valid", 64'(out_valid), 64'd0);
    chk("rx_rdy", 64'(write_rdy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("rx_no_done", 64'({done, out_valid}), 64'd0);
    end
    wr(4'd0, 64'h840);
    run_op(lit(64'h0, 4'b0000, 2'd0));

    // Write and start in the same cycle
    wr(4'd1, 64'h0001_FFFF_0002_0003);
    write_en = 1'b1;
    w_addr = 4'd2;
    w_data_in = 64'h0002_0002_0002_0002;
    shadow[2] = w_data_in;
    ack1 = 1'b0;
    run_op(lit(64'h0003_0001_0004_0005, 4'b0100, 2'd0));
    chk("ws_ack", 64'(ack1), 64'd1);

    // Randomised ops over all modes including the clamped one
    for (int i = 0; i < 8; i++) begin
      r1 = {$urandom, $urandom};
      r2 = (i % 2 == 0) ? {$urandom, $urandom} : ~r1;
      wr(4'd1, r1);
      wr(4'd2, r2);
      wr(4'd3, {$urandom, $urandom});
      cfg = {$urandom, $urandom};
      cfg[1:0] = 2'(i);
      cfg[6 +: AW] = 4'($urandom_range(0, 3));
      cfg[6+AW +: AW] = 4'($urandom_range(0, 3));
      wr(4'd0, cfg);
      run_op(from_shadow());
    end

    repeat (3) tick();
    chk("done_count", 64'(n_done), 64'(n_ops));
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
